truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning wait cycles between applying a vector and sampling the response (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a sweep.
REQ-005 The block SHALL have port n_vars, input, 2 bits, the number of variables; 1..3 are valid and 0 is treated as 1; sampled only on an accepted start.
REQ-006 The block SHALL have ports x, y, z, output, 1 bit each, driving the combinational function under test.
REQ-007 The block SHALL have port dut_s, input, 1 bit, the response of the function under test.
REQ-008 The block SHALL have port busy, output, 1 bit, high from the accepted start through the last emitted term.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse when the sweep and emission finish.
REQ-010 The block SHALL have port tt, output, 8 bits, the captured truth table, where bit i equals f(index i).
REQ-011 The block SHALL have port min_count, output, 4 bits, the number of 1 entries in tt.
REQ-012 The block SHALL have ports term_valid (output, 1), term_ready (input, 1), term_idx (output, 3) and term_is_min (output, 1), forming the stream of minterms and maxterms.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, WAIT, SAMPLE, EMIT and FIN.
REQ-014 In IDLE, start=1 SHALL latch n_vars, clear tt, min_count and the index, and move to DRIVE; start outside IDLE SHALL be ignored.
REQ-015 The index-to-input mapping SHALL be: n=3 gives {x,y,z}=idx; n=2 gives {x,y}=idx with z=0; n=1 gives x=idx with y=z=0.
REQ-016 DRIVE SHALL apply the vector for the current index, WAIT SHALL hold it for SETTLE-1 further cycles (skipped when SETTLE=1), and SAMPLE SHALL write dut_s into tt[idx] and add it to min_count.
REQ-017 After SAMPLE, the FSM SHALL go to DRIVE with idx+1 if idx<2^n-1, otherwise to EMIT with idx=0 and x, y and z returned to 0.
REQ-018 For n=3 and SETTLE=1, the sweep SHALL take exactly 8 vectors at 2 cycles each, so tt is final 16 cycles after the start cycle.
REQ-019 In EMIT, the block SHALL drive term_valid=1, term_idx=idx and term_is_min=tt[idx]; a transfer SHALL occur when valid and ready are both high at a clock edge.
REQ-020 While term_ready is 0, term_idx and term_is_min SHALL remain stable and term_valid SHALL stay 1.
REQ-021 On the transfer of index 2^n-1, the FSM SHALL go to FIN; FIN SHALL pulse done for one cycle, deassert busy, and return to IDLE.
REQ-022 tt bits at indices of 2^n and above SHALL read 0, and tt and min_count SHALL hold their values until the next accepted start.
REQ-023 min_count SHALL never exceed 2^n, and its 4-bit width SHALL cover the value 8 without wrap-around.

Reset
REQ-024 Asserting rst_n low at any time, including mid-sweep or mid-emission, SHALL immediately force state=IDLE, x=y=z=0, busy=0, done=0, term_valid=0, term_idx=0, term_is_min=0, tt=0 and min_count=0.
REQ-025 After rst_n is released, the block SHALL do nothing until a new start, and it SHALL NOT resume an interrupted sweep.

Structure
REQ-026 A shared package SHALL hold the state enumeration, MAX_VARS=3, and TT_W=8.
REQ-027 One sub-module, sweep_index_counter (index, terminal-count compare against 2^n-1, and the vector mapping of REQ-015), SHALL be instantiated once.

Verification
REQ-028 With n_vars=2, SETTLE=1 and dut_s=x^y, the bench SHALL check tt=8'h06, min_count=2, terms (0,max), (1,min), (2,min), (3,max), and then one done pulse.
REQ-029 With n_vars=3 and dut_s=(~x|y)&(y|z), the bench SHALL check tt=8'hCE, min_count=5, eight terms with minterms at 1, 2, 3, 6 and 7, and tt final at cycle 16.
REQ-030 With n_vars=1, SETTLE=3 and dut_s=x, the bench SHALL check tt=8'h02 and min_count=1, with each vector held for 3 cycles before its sample.
REQ-031 With term_ready held low for 5 cycles during EMIT of index 2, the bench SHALL check that term_valid stays 1, term_idx stays 2, and no index is skipped or repeated.
REQ-032 The bench SHALL drop rst_n at sweep index 4 and check that all outputs are 0 at once; it SHALL then pulse start during a sweep and check that it is ignored and the current results are unchanged.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants and helpers for the truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int unsigned MAX_VARS = 3;
  localparam int unsigned TT_W     = 8;
  localparam int unsigned IDX_W    = MAX_VARS;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned ST_W     = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_DRIVE  = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [ST_W-1:0] ST_SAMPLE = 3'd3;
  localparam logic [ST_W-1:0] ST_EMIT   = 3'd4;
  localparam logic [ST_W-1:0] ST_FIN    = 3'd5;

  // A variable count of 0 behaves like 1.
  function automatic logic [1:0] norm_vars(input logic [1:0] n);
    return (n == 2'd0) ? 2'd1 : n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_sweep_index_counter.sv
// Sweep index register, terminal-count compare and index-to-vector mapping.
module sweep_index_counter
  import truth_table_sweeper_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic             inc,
  input  logic [1:0]       n_vars,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_next_c,
  output logic             last_c,
  output logic [2:0]       vec_c
);

  logic [1:0] n_cur;
  logic [1:0] n_next;

  // Next index/variable count; vec_c maps the index that will be current next cycle.
  always_comb begin
    n_next     = load ? norm_vars(n_vars) : n_cur;
    idx_next_c = idx;
    if (load || clr) begin
      idx_next_c = '0;
    end else if (inc) begin
      idx_next_c = idx + IDX_W'(1);
    end
    case (n_cur)
      2'd3:    last_c = (idx == IDX_W'(7));
      2'd2:    last_c = (idx == IDX_W'(3));
      default: last_c = (idx == IDX_W'(1));
    endcase
    case (n_next)
      2'd3:    vec_c = idx_next_c;
      2'd2:    vec_c = {idx_next_c[1:0], 1'b0};
      default: vec_c = {idx_next_c[0], 2'b00};
    endcase
  end

  // Index and latched variable count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      n_cur <= 2'd1;
    end else begin
      idx   <= idx_next_c;
      n_cur <= n_next;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a 1..3 variable function, captures its truth
// table, then streams each index out as a minterm or maxterm.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       n_vars,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             dut_s,
  output logic             busy,
  output logic             done,
  output logic [TT_W-1:0]  tt,
  output logic [CNT_W-1:0] min_count,
  output logic             term_valid,
  input  logic             term_ready,
  output logic [IDX_W-1:0] term_idx,
  output logic             term_is_min
);

  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

  logic [ST_W-1:0]  state, state_d;
  logic [TT_W-1:0]  tt_d;
  logic [CNT_W-1:0] min_count_d;
  logic [CNT_W-1:0] wcnt, wcnt_d;
  logic [2:0]       vec_q, vec_d;
  logic             busy_d, done_d, term_valid_d, term_is_min_d;
  logic [IDX_W-1:0] term_idx_d;
  logic             load, clr, inc;
  logic [IDX_W-1:0] idx, idx_next_c;
  logic             last_c;
  logic [2:0]       vec_c;

  sweep_index_counter u_idx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .clr        (clr),
    .inc        (inc),
    .n_vars     (n_vars),
    .idx        (idx),
    .idx_next_c (idx_next_c),
    .last_c     (last_c),
    .vec_c      (vec_c)
  );

  // Next-state and next-output logic; every output is computed for the next state.
  always_comb begin
    state_d     = state;
    tt_d        = tt;
    min_count_d = min_count;
    wcnt_d      = wcnt;
    load        = 1'b0;
    clr         = 1'b0;
    inc         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load        = 1'b1;
          tt_d        = '0;
          min_count_d = '0;
          state_d     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        wcnt_d  = CNT_W'(1);
        state_d = (SETTLE <= 1) ? ST_SAMPLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (wcnt >= SETTLE_M1) begin
          state_d = ST_SAMPLE;
        end else begin
          wcnt_d = wcnt + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        tt_d[idx]   = dut_s;
        min_count_d = min_count + CNT_W'(dut_s);
        if (last_c) begin
          clr     = 1'b1;
          state_d = ST_EMIT;
        end else begin
          inc     = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_EMIT: begin
        if (term_ready) begin
          if (last_c) begin
            state_d = ST_FIN;
          end else begin
            inc = 1'b1;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    vec_d         = (state_d inside {ST_DRIVE, ST_WAIT, ST_SAMPLE}) ? vec_c : 3'b000;
    busy_d        = state_d inside {ST_DRIVE, ST_WAIT, ST_SAMPLE, ST_EMIT};
    done_d        = (state_d == ST_FIN);
    term_valid_d  = (state_d == ST_EMIT);
    term_idx_d    = term_valid_d ? idx_next_c : '0;
    term_is_min_d = term_valid_d & tt_d[idx_next_c];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tt          <= '0;
      min_count   <= '0;
      wcnt        <= '0;
      vec_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      term_valid  <= 1'b0;
      term_idx    <= '0;
      term_is_min <= 1'b0;
    end else begin
      state       <= state_d;
      tt          <= tt_d;
      min_count   <= min_count_d;
      wcnt        <= wcnt_d;
      vec_q       <= vec_d;
      busy        <= busy_d;
      done        <= done_d;
      term_valid  <= term_valid_d;
      term_idx    <= term_idx_d;
      term_is_min <= term_is_min_d;
    end
  end

  assign {x, y, z} = vec_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (SETTLE=1 and SETTLE=3 instances).
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start3;
  logic [1:0] n_vars, n_vars3;
  logic       x, y, z, x3, y3, z3;
  logic       dut_s, dut_s3;
  logic       busy, done, busy3, done3;
  logic [7:0] tt, tt3;
  logic [3:0] min_count, min_count3;
  logic       term_valid, term_ready, term_is_min;
  logic       term_valid3, term_ready3, term_is_min3;
  logic [2:0] term_idx, term_idx3;
  logic       mode;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dut_s  = (mode == 1'b0) ? (x ^ y) : ((~x | y) & (y | z));
  assign dut_s3 = x3;

  truth_table_sweeper #(.SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_vars(n_vars),
    .x(x), .y(y), .z(z), .dut_s(dut_s), .busy(busy), .done(done),
    .tt(tt), .min_count(min_count), .term_valid(term_valid),
    .term_ready(term_ready), .term_idx(term_idx), .term_is_min(term_is_min)
  );

  truth_table_sweeper #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .n_vars(n_vars3),
    .x(x3), .y(y3), .z(z3), .dut_s(dut_s3), .busy(busy3), .done(done3),
    .tt(tt3), .min_count(min_count3), .term_valid(term_valid3),
    .term_ready(term_ready3), .term_idx(term_idx3), .term_is_min(term_is_min3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] n);
    start  = 1'b1;
    n_vars = n;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!term_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("wait_term_valid", term_valid, 1);
  endtask

  // Walk the term stream in order, optionally stalling on one index.
  task automatic collect(input int n, input logic [7:0] exp_tt, input int stall_idx);
    for (int k = 0; k < (1 << n); k++) begin
      wait_valid();
      check("term_idx", term_idx, k);
      check("term_is_min", term_is_min, exp_tt[k]);
      if (k == stall_idx) begin
        term_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", term_valid, 1);
          check("stall_idx", term_idx, k);
        end
        term_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("busy_fin", busy, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("valid_after", term_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n = 1'b0; start = 1'b0; n_vars = 2'd0; term_ready = 1'b1; mode = 1'b0;
    start3 = 1'b0; n_vars3 = 2'd0; term_ready3 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tt", tt, 0);
    check("rst_min_count", min_count, 0);
    check("rst_term_valid", term_valid, 0);
    check("rst_xyz", {x, y, z}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // n=2, f = x ^ y
    mode = 1'b0;
    do_start(2'd2);
    check("t1_busy", busy, 1);
    wait_valid();
    check("t1_tt", tt, 8'h06);
    check("t1_min_count", min_count, 2);
    collect(2, 8'h06, -1);

    // n=3, f = (~x|y)&(y|z); ignored mid-sweep start, cycle-16 finality, EMIT stall
    mode = 1'b1;
    do_start(2'd3);
    repeat (4) @(negedge clk);
    start = 1'b1; n_vars = 2'd1;
    @(negedge clk);
    start = 1'b0; n_vars = 2'd3;
    check("t2_busy_ignored_start", busy, 1);
    repeat (10) @(negedge clk);
    check("t2_tt_cycle15", tt, 8'h4E);
    check("t2_valid_cycle15", term_valid, 0);
    @(negedge clk);
    check("t2_tt_cycle16", tt, 8'hCE);
    check("t2_min_count", min_count, 5);
    check("t2_emit_valid", term_valid, 1);
    check("t2_emit_xyz", {x, y, z}, 0);
    collect(3, 8'hCE, 2);
    repeat (3) @(negedge clk);
    check("t2_tt_hold", tt, 8'hCE);
    check("t2_min_hold", min_count, 5);
    check("t2_idle_busy", busy, 0);

    // Reset at sweep index 4
    do_start(2'd3);
    t = 0;
    while (!(x && !y && !z) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t3_reach_idx4", {x, y, z}, 3'b100);
    check("t3_partial_tt", tt, 8'h0E);
    check("t3_partial_min", min_count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t3_rst_busy", busy, 0);
    check("t3_rst_done", done, 0);
    check("t3_rst_tt", tt, 0);
    check("t3_rst_min", min_count, 0);
    check("t3_rst_xyz", {x, y, z}, 0);
    check("t3_rst_term", {term_valid, term_idx, term_is_min}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_no_resume_busy", busy, 0);
    check("t3_no_resume_valid", term_valid, 0);
    check("t3_no_resume_tt", tt, 0);

    // SETTLE=3, n=1, f = x
    start3 = 1'b1; n_vars3 = 2'd1;
    @(negedge clk);
    start3 = 1'b0;
    check("t4_busy", busy3, 1);
    repeat (3) @(negedge clk);
    check("t4_x_vec0", x3, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_x_vec1_hold", x3, 1);
      check("t4_yz", {y3, z3}, 0);
    end
    check("t4_tt_pre", tt3, 8'h00);
    @(negedge clk);
    check("t4_tt", tt3, 8'h02);
    check("t4_min_count", min_count3, 1);
    check("t4_term0", {term_valid3, term_idx3, term_is_min3}, {1'b1, 3'd0, 1'b0});
    check("t4_x_emit", x3, 0);
    @(negedge clk);
    check("t4_term1", {term_valid3, term_idx3, term_is_min3}, {1'b1, 3'd1, 1'b1});
    @(negedge clk);
    check("t4_done", {done3, busy3}, 2'b10);
    @(negedge clk);
    check("t4_done_once", done3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
